// File: rtl/cic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_pkg: shared CIC sample-path constants and round/saturate helper   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cic_pkg;

  localparam int CIC_OUT_W = 25;
  localparam int SAMPLE_W  = 16;
  localparam int DECIM_DEF = 64;

  // Works on a 64-bit signed copy of the input, so the half-LSB add never wraps.
  function automatic logic signed [63:0] round_sat(
    input logic signed [63:0] x,
    input int                 shift,
    input int                 out_w
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = x;
    if (shift > 0) begin
      v = v + (64'sd1 <<< (shift - 1));
    end
    v  = v >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo: single-clock show-ahead FIFO with occupancy count          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_clear,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int                     c_addr_w = $clog2(DEPTH);
  localparam logic [c_addr_w:0]      c_full   = (c_addr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_level;
  logic                w_rd;
  logic                w_wr;

  assign o_valid   = (r_level != '0);
  assign o_full    = (r_level == c_full);
  assign o_level   = r_level;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign w_rd      = i_rd_en && o_valid;
  assign w_wr      = i_wr_en && (!o_full || w_rd);
  assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_wr && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (c_addr_w + 1)'(1);
        2'b01:   r_level <= r_level - (c_addr_w + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cic_sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_sample_buffer: decimate, round/saturate and buffer CIC output     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cic_sample_buffer
  import cic_pkg::*;
#(
  parameter int DECIM = DECIM_DEF,
  parameter int IN_W  = CIC_OUT_W,
  parameter int SHIFT = 9,
  parameter int OUT_W = SAMPLE_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IN_W-1:0]          cic_in,
  input  logic                     enable,
  input  logic                     clear,
  output logic [OUT_W-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int               c_cnt_w    = $clog2(DECIM);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DECIM - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pend_v;
  logic [OUT_W-1:0]   r_pend_data;
  logic               r_overflow;
  logic               w_strobe;
  logic signed [63:0] w_ext;
  logic [OUT_W-1:0]   w_sample;
  logic               w_full;
  logic               w_rd;
  logic               w_drop;

  assign w_strobe = enable && (r_cnt == c_cnt_last);
  assign w_ext    = {{(64 - IN_W){cic_in[IN_W-1]}}, cic_in};
  assign w_sample = OUT_W'(round_sat(w_ext, SHIFT, OUT_W));
  assign w_rd     = dout_valid && dout_ready;
  assign w_drop   = r_pend_v && w_full && !w_rd;
  assign overflow = r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_pend_v    <= 1'b0;
      r_pend_data <= '0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_cnt       <= '0;
      r_pend_v    <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (enable) begin
        r_cnt <= w_strobe ? '0 : r_cnt + c_cnt_w'(1);
      end
      // The registered sample lands in the FIFO next cycle even if enable drops.
      r_pend_v <= w_strobe;
      if (w_strobe) begin
        r_pend_data <= w_sample;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (clear),
    .i_wr_en   (r_pend_v),
    .i_wr_data (r_pend_data),
    .i_rd_en   (dout_ready),
    .o_rd_data (dout),
    .o_valid   (dout_valid),
    .o_full    (w_full),
    .o_level   (level)
  );

endmodule
`default_nettype wire

// File: doc/cic_sample_buffer.md
CIC_SAMPLE_BUFFER -- requirements
Module: cic_sample_buffer

Interface
REQ-001 SHALL have parameter DECIM, default 64, decimation ratio; samples taken every DECIM clk cycles (legal 2..1024).
REQ-002 SHALL have parameter IN_W, default 25, width of CIC filter output.
REQ-003 SHALL have parameter SHIFT, default 9, LSBs dropped by rounding.
REQ-004 SHALL have parameter OUT_W, default 16, output sample width.
REQ-005 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, >=2).
REQ-006 SHALL have port clk  input  1  single system clock, shared with the modulator and CIC.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port cic_in  input  IN_W  two's-complement CIC output (the CIC's `out`).
REQ-009 SHALL have port enable  input  1  when low, the decimation counter holds and no samples are captured.
REQ-010 SHALL have port clear  input  1  synchronous flush of the FIFO, the counter and the overflow flag.
REQ-011 SHALL have port dout  output  OUT_W  head-of-FIFO sample.
REQ-012 SHALL have port dout_valid  output  1  FIFO not empty.
REQ-013 SHALL have port dout_ready  input  1  consumer accepts the head when high with dout_valid.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port overflow  output  1  sticky; set when a sample is dropped.

Function
REQ-016 Decimation counter SHALL count 0..DECIM-1 while enable=1 and wrap to 0; the capture strobe SHALL fire on the cycle the count equals DECIM-1.
REQ-017 First strobe after reset release or clear SHALL occur DECIM enabled cycles later.
REQ-018 Rounding SHALL be round-half-up: add 2^(SHIFT-1), then arithmetic shift right by SHIFT; computed with IN_W+1 bits to avoid wrap.
REQ-019 Result SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; for SHIFT=0 no rounding constant is added.
REQ-020 Round/saturate SHALL be registered: the sample is written to the FIFO one cycle after the strobe (capture latency 1 cycle; write visible on dout_valid/dout 2 cycles after strobe when FIFO was empty).
REQ-021 Read SHALL occur on a cycle with dout_valid=1 and dout_ready=1; dout SHALL present the next entry on the following cycle (show-ahead FIFO).
REQ-022 Write to a full FIFO SHALL drop the new sample, keep the stored contents and set overflow.
REQ-023 Simultaneous write and read when full SHALL NOT count as overflow; both SHALL complete and level SHALL be unchanged.
REQ-024 Simultaneous write and read when empty SHALL leave the written sample stored (no bypass); level goes 0->1.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; level SHALL equal the number of writes minus the number of reads, in 0..DEPTH.
REQ-026 clear SHALL take priority over a write and a read in the same cycle; the next cycle SHALL show level=0, dout_valid=0, overflow=0, counter=0, and the pending rounded sample discarded.
REQ-027 Deasserting enable SHALL not affect FIFO reads; the pending registered sample SHALL still be written.

Reset
REQ-028 reset_n low SHALL asynchronously force counter=0, pointers=0, level=0, dout_valid=0, overflow=0, dout=0, pending-write flag=0.
REQ-029 Reset deassertion mid-operation SHALL lose all buffered samples; FIFO storage contents need not be reset.

Structure
REQ-030 Shared package cic_pkg SHALL hold default constants (CIC_OUT_W=25, SAMPLE_W=16, DECIM_DEF=64) and the round/saturate function.
REQ-031 Storage and pointers SHALL live in one sub-module sync_fifo (parameterised width/depth, show-ahead); counter and rounding SHALL stay in the top level.

Verification
REQ-032 Bench SHALL drive a constant cic_in=0x000300 (768), DECIM=64, ready=1 -> dout=2 (768/512=1.5 rounds up); first dout_valid 66 cycles after reset release.
REQ-033 Bench SHALL drive cic_in=0x0FFFFFF (max positive) and then 0x1000000 (min negative) -> dout=0x7FFF and then 0x8000, respectively.
REQ-034 Bench SHALL hold ready=0 for 9 strobes -> level=8 after 8 strobes, overflow=1 after the 9th, FIFO holds the first 8 samples in order.
REQ-035 Bench SHALL assert clear while level=5 and a strobe is pending -> the next cycle shows level=0, dout_valid=0, overflow=0, and the next strobe occurs 64 cycles after clear.
REQ-036 Bench SHALL assert reset_n low mid-stream for one cycle -> all outputs go to 0 immediately without a clock edge, and capture resumes after 64 cycles.
REQ-037 Bench SHALL connect sine_wave -> sdm_rnm -> cic3_echip65 -> this block with random ready -> no overflow at 50% ready duty, and samples track the sine.
